// File: rtl/tick_monitor_pkg.sv
// Shared types and constants for the seconds-clock receive path.
package tick_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      TRACKING,
      LOST
   } state_t;

   localparam int unsigned CNT_W   = 32;
   localparam int unsigned SEC_MOD = 60;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for a slow asynchronous level, plus a rising-edge flag
// taken from the synchronized value and its one-cycle-delayed copy.
module sync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= async_in;
         sync <= meta;
         prev <= sync;
      end
   end

   assign rise = sync & ~prev;

endmodule

// File: rtl/second_tick_monitor.sv
// Receives the divided seconds clock, emits a tick per rising edge, measures
// its period, tracks lock/fault status and keeps a 0..59 seconds count.
module second_tick_monitor
   import tick_monitor_pkg::*;
#(
   parameter int unsigned EXPECTED_PERIOD = 10000000,
   parameter int unsigned TOLERANCE       = 1000,
   parameter int unsigned LOCK_GOOD       = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        slow_in,
   input  logic        clear_faults,
   output logic        tick,
   output logic [31:0] period,
   output logic        period_valid,
   output logic        locked,
   output logic        fault_fast,
   output logic        fault_slow,
   output logic [5:0]  seconds,
   output logic        minute_tick
);

   localparam logic [CNT_W-1:0] P_MIN    = EXPECTED_PERIOD - TOLERANCE;
   localparam logic [CNT_W-1:0] P_MAX    = EXPECTED_PERIOD + TOLERANCE;
   localparam logic [CNT_W-1:0] P_SAT    = P_MAX + 1;
   localparam logic [5:0]       SEC_LAST = 6'(SEC_MOD - 1);

   state_t           state_q, state_n;
   logic [CNT_W-1:0] elapsed_q;
   logic [CNT_W-1:0] good_q, good_n;
   logic             rise;
   logic             good_period;
   logic             locked_n;
   logic [5:0]       seconds_n;
   logic             minute_n;
   logic             pv_n;
   logic [31:0]      period_n;
   logic             set_fast;
   logic             set_slow;

   sync_edge_detect u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (slow_in),
      .rise     (rise)
   );

   assign good_period = (elapsed_q >= P_MIN) && (elapsed_q <= P_MAX);

   always_comb begin
      state_n   = state_q;
      good_n    = good_q;
      locked_n  = locked;
      seconds_n = seconds;
      minute_n  = 1'b0;
      pv_n      = 1'b0;
      period_n  = period;
      set_fast  = 1'b0;
      set_slow  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) state_n = ARMED;
         end
         ARMED, TRACKING: begin
            if (rise) begin
               period_n = elapsed_q;
               pv_n     = 1'b1;
               if (good_period) begin
                  if (state_q == ARMED) begin
                     good_n = good_q + CNT_W'(1);
                     if (good_n >= LOCK_GOOD) begin
                        state_n  = TRACKING;
                        locked_n = 1'b1;
                     end
                  end else if (seconds == SEC_LAST) begin
                     seconds_n = '0;
                     minute_n  = 1'b1;
                  end else begin
                     seconds_n = seconds + 6'd1;
                  end
               end else begin
                  set_fast = (elapsed_q < P_MIN);
                  set_slow = (elapsed_q > P_MAX);
                  good_n   = '0;
                  locked_n = 1'b0;
                  state_n  = ARMED;
               end
            // elapsed_q becomes P_SAT on this edge, so the fault shows with it
            end else if (elapsed_q == P_MAX) begin
               set_slow = 1'b1;
               good_n   = '0;
               locked_n = 1'b0;
               state_n  = LOST;
            end
         end
         LOST: begin
            if (rise) state_n = ARMED;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         elapsed_q    <= '0;
         good_q       <= '0;
         tick         <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         fault_fast   <= 1'b0;
         fault_slow   <= 1'b0;
         seconds      <= '0;
         minute_tick  <= 1'b0;
      end else begin
         state_q      <= state_n;
         good_q       <= good_n;
         tick         <= rise;
         period       <= period_n;
         period_valid <= pv_n;
         locked       <= locked_n;
         seconds      <= seconds_n;
         minute_tick  <= minute_n;
         if (rise) begin
            elapsed_q <= CNT_W'(1);
         end else if (elapsed_q != P_SAT) begin
            elapsed_q <= elapsed_q + CNT_W'(1);
         end
         fault_fast <= set_fast | (fault_fast & ~clear_faults);
         fault_slow <= set_slow | (fault_slow & ~clear_faults);
      end
   end

endmodule

// File: tb/tb_second_tick_monitor.sv
// Directed bench: EXPECTED_PERIOD=20, TOLERANCE=2, LOCK_GOOD=3; slow_in is
// driven as whole periods and DUT outputs are captured on each tick.
module tb_second_tick_monitor;

   logic        clk;
   logic        reset;
   logic        slow_in;
   logic        clear_faults;
   logic        tick;
   logic [31:0] period;
   logic        period_valid;
   logic        locked;
   logic        fault_fast;
   logic        fault_slow;
   logic [5:0]  seconds;
   logic        minute_tick;

   int n_tests = 0;
   int n_fail  = 0;

   // Per-period capture, filled by run_period
   int          tick_cnt, pv_cnt, min_cnt, slow_rise_it;
   logic [31:0] s_period;
   logic        s_pv, s_locked, s_minute, s_ff, s_fs;
   logic [5:0]  s_seconds;
   int          exp_sec;

   second_tick_monitor #(
      .EXPECTED_PERIOD (20),
      .TOLERANCE       (2),
      .LOCK_GOOD       (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .slow_in      (slow_in),
      .clear_faults (clear_faults),
      .tick         (tick),
      .period       (period),
      .period_valid (period_valid),
      .locked       (locked),
      .fault_fast   (fault_fast),
      .fault_slow   (fault_slow),
      .seconds      (seconds),
      .minute_tick  (minute_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One slow_in period of p cycles (rising at iteration 0); clear_faults is
   // high during iteration clr_at. Sampling is 1 time unit after each posedge.
   task automatic run_period(input int p, input int clr_at);
      int   h;
      logic prev_fs;
      h            = p / 2;
      tick_cnt     = 0;
      pv_cnt       = 0;
      min_cnt      = 0;
      slow_rise_it = -1;
      prev_fs      = fault_slow;
      for (int i = 0; i < p; i++) begin
         slow_in      = (i < h);
         clear_faults = (i == clr_at);
         @(posedge clk);
         #1;
         if (tick) begin
            tick_cnt++;
            s_period  = period;
            s_pv      = period_valid;
            s_locked  = locked;
            s_seconds = seconds;
            s_minute  = minute_tick;
            s_ff      = fault_fast;
            s_fs      = fault_slow;
         end
         if (period_valid) pv_cnt++;
         if (minute_tick) min_cnt++;
         if (fault_slow && !prev_fs && slow_rise_it < 0) slow_rise_it = i;
         prev_fs = fault_slow;
      end
      clear_faults = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      slow_in      = 1'b0;
      clear_faults = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tick", tick, 0);
      check("rst_period", period, 0);
      check("rst_pv", period_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_ff", fault_fast, 0);
      check("rst_fs", fault_slow, 0);
      check("rst_seconds", seconds, 0);
      check("rst_minute", minute_tick, 0);
      reset = 1'b0;

      // Clean lock
      run_period(20, -1);
      check("p1_ticks", tick_cnt, 1);
      check("p1_pv", pv_cnt, 0);
      run_period(20, -1);
      check("p2_pv", s_pv, 1);
      check("p2_period", s_period, 20);
      check("p2_locked", s_locked, 0);
      run_period(20, -1);
      check("p3_locked", s_locked, 0);
      run_period(20, -1);
      check("p4_locked", s_locked, 1);
      check("p4_seconds", s_seconds, 0);
      run_period(17, -1);
      check("p5_seconds", s_seconds, 1);
      check("p5_ticks", tick_cnt, 1);

      // Fast period of 17 measured at this tick
      run_period(20, -1);
      check("fast_period", s_period, 17);
      check("fast_ff", s_ff, 1);
      check("fast_locked", s_locked, 0);
      check("fast_seconds", s_seconds, 1);
      run_period(20, -1);
      check("relock1", s_locked, 0);
      run_period(20, -1);
      check("relock2", s_locked, 0);

      // Third good period relocks; clear fast fault, then let input stall
      run_period(40, 10);
      check("relock3", s_locked, 1);
      check("relock_fs", s_fs, 0);
      check("clr_ff", fault_fast, 0);
      check("to_at", slow_rise_it, 24);
      check("to_fs", fault_slow, 1);
      check("to_locked", locked, 0);
      check("to_seconds", seconds, 1);

      run_period(20, 10);
      check("lost_ticks", tick_cnt, 1);
      check("lost_pv", pv_cnt, 0);
      check("lost_clr_fs", fault_slow, 0);

      // Clear collides with the timeout fault of a long (25) period
      run_period(25, 24);
      check("col_pv", s_pv, 1);
      check("col_period", s_period, 20);
      check("col_fs_before", s_fs, 0);
      check("col_at", slow_rise_it, 24);
      check("col_fs", fault_slow, 1);
      run_period(20, 10);
      check("col_pv_after", pv_cnt, 0);
      check("col_clr_fs", fault_slow, 0);

      run_period(20, -1);
      run_period(20, -1);
      check("lock2_pre", s_locked, 0);
      run_period(20, -1);
      check("lock2", s_locked, 1);
      check("lock2_seconds", s_seconds, 1);

      // Wrap through 59 -> 0 and on to 37
      exp_sec = 1;
      for (int k = 0; k < 96; k++) begin
         run_period(20, -1);
         exp_sec = (exp_sec + 1) % 60;
         check("wrap_seconds", s_seconds, exp_sec);
         check("wrap_minute", min_cnt, (exp_sec == 0) ? 1 : 0);
         check("wrap_minute_at_tick", s_minute, (exp_sec == 0) ? 1 : 0);
      end
      check("pre_rst_seconds", seconds, 37);
      check("pre_rst_locked", locked, 1);

      // Reset while locked, slow_in high through and after reset
      reset   = 1'b1;
      slow_in = 1'b1;
      @(posedge clk);
      #1;
      check("mid_tick", tick, 0);
      check("mid_period", period, 0);
      check("mid_pv", period_valid, 0);
      check("mid_locked", locked, 0);
      check("mid_ff", fault_fast, 0);
      check("mid_fs", fault_slow, 0);
      check("mid_seconds", seconds, 0);
      check("mid_minute", minute_tick, 0);
      reset = 1'b0;
      run_period(20, -1);
      check("post_ticks", tick_cnt, 1);
      check("post_pv", pv_cnt, 0);
      check("post_seconds", s_seconds, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
